// File: rtl/fifo_wm_pkg.sv
// rtl/fifo_wm_pkg.sv - sizing helpers shared by the watermark FIFO files
// Purpose: derive the capacity and size-field width from DEPTH/OREG so the
//          top and any wrapper compute them identically.
// Ports:   none (package).
package fifo_wm_pkg;

    // Total words held: the array plus the optional output register stage.
    function automatic int fifo_cap(input int depth, input int oreg);
        return depth + ((oreg != 0) ? 1 : 0);
    endfunction

    // Width needed for 0..CAP; DEPTH is a power of two, so one bit above the
    // pointer width covers DEPTH+1 as well.
    function automatic int size_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_wm_mem.sv
// rtl/fifo_wm_mem.sv - FIFO storage array, one sync write port, one async read port
// Purpose: isolated storage so a vendor RAM primitive can be dropped in.
// Ports:   clk             write clock
//          we/waddr/wdata  synchronous write port
//          raddr/rdata     asynchronous read port
module fifo_wm_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // No reset: contents are only ever read behind a valid occupancy count.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_wm.sv
// rtl/fifo_wm.sv - valid/ready FIFO with runtime thresholds and high-water mark
// Purpose: elastic buffer between producer/consumer pipes; flags backpressure
//          ahead of full and records peak occupancy for firmware profiling.
// Ports:   clk, rstz (async active-low), clear (sync flush)
//          af_level/ae_level   almost_full / almost_empty thresholds
//          wm_clr              clears max_level only
//          din/din_vld/din_rdy     write side
//          dout/dout_vld/dout_rdy  read side
//          size, full, empty, almost_full, almost_empty, max_level  status
module fifo_wm
    import fifo_wm_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32,
    parameter int OREG  = 1,
    localparam int SW   = size_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rstz,
    input  logic             clear,
    input  logic [SW-1:0]    af_level,
    input  logic [SW-1:0]    ae_level,
    input  logic             wm_clr,
    input  logic [WIDTH-1:0] din,
    input  logic             din_vld,
    output logic             din_rdy,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    input  logic             dout_rdy,
    output logic [SW-1:0]    size,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [SW-1:0]    max_level
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CAP = fifo_cap(DEPTH, OREG);
    localparam logic [SW-1:0] CAP_SZ = SW'(CAP);

    logic             push;
    logic             pop;
    logic             mem_we;
    logic             arr_pop;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [SW-1:0]    size_next;
    logic [WIDTH-1:0] mem_rdata;

    // Status comes straight off the registered count.
    assign full         = (size == CAP_SZ);
    assign empty        = (size == '0);
    assign almost_full  = (size >= af_level);
    assign almost_empty = (size <= ae_level);
    assign din_rdy      = ~full;
    assign dout_vld     = ~empty;

    // clear wins: words offered in a flush cycle are neither taken nor given.
    // din_rdy is ~full, so a pop while full never frees a same-cycle push.
    assign push = din_vld & din_rdy & ~clear;
    assign pop  = dout_vld & dout_rdy & ~clear;

    always_comb begin
        size_next = size;
        if (clear) begin
            size_next = '0;
        end else if (push & ~pop) begin
            size_next = size + SW'(1);
        end else if (pop & ~push) begin
            size_next = size - SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            size      <= '0;
            max_level <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
        end else begin
            size <= size_next;
            if (clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (mem_we) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (arr_pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
            end
            if (clear | wm_clr) begin
                max_level <= '0;
            end else if (size_next > max_level) begin
                max_level <= size_next;
            end
        end
    end

    fifo_wm_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr),
        .wdata (din),
        .raddr (rd_ptr),
        .rdata (mem_rdata)
    );

    generate
        if (OREG != 0) begin : g_oreg
            // The output register holds the oldest word whenever size>0, so the
            // array holds size-1 words and is empty when size<=1.
            logic [WIDTH-1:0] oreg_data;
            logic             arr_empty;
            logic             bypass;

            assign arr_empty = (size <= SW'(1));
            // A push lands directly in the output register when that register
            // is (or is about to become) free and nothing older waits in the array.
            assign bypass    = push & (empty | (pop & arr_empty));
            assign arr_pop   = pop & ~arr_empty;
            assign mem_we    = push & ~bypass;

            always_ff @(posedge clk or negedge rstz) begin
                if (!rstz) begin
                    oreg_data <= '0;
                end else if (bypass) begin
                    oreg_data <= din;
                end else if (arr_pop) begin
                    oreg_data <= mem_rdata;
                end
            end

            assign dout = oreg_data;
        end else begin : g_noreg
            assign mem_we  = push;
            assign arr_pop = pop;
            // Mask the array read while empty so dout is 0 out of reset.
            assign dout    = empty ? '0 : mem_rdata;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_wm.sv
// tb/tb_fifo_wm.sv - directed self-checking bench for fifo_wm (OREG=1 and OREG=0)
module tb_fifo_wm;

    logic       clk;
    logic       rstz;
    int         checks;
    int         errors;

    // OREG=1 instance signals
    logic       clear, wm_clr, din_vld, din_rdy, dout_vld, dout_rdy;
    logic       full, empty, almost_full, almost_empty;
    logic [5:0] af_level, ae_level, size, max_level;
    logic [7:0] din, dout;

    // OREG=0 instance signals
    logic       u0_clear, u0_wm_clr, u0_din_vld, u0_din_rdy, u0_dout_vld, u0_dout_rdy;
    logic       u0_full, u0_empty, u0_af, u0_ae;
    logic [5:0] u0_af_level, u0_ae_level, u0_size, u0_max;
    logic [7:0] u0_din, u0_dout;

    logic [7:0] q[$];

    fifo_wm #(.WIDTH(8), .DEPTH(32), .OREG(1)) u_dut1 (
        .clk(clk), .rstz(rstz), .clear(clear), .af_level(af_level), .ae_level(ae_level),
        .wm_clr(wm_clr), .din(din), .din_vld(din_vld), .din_rdy(din_rdy),
        .dout(dout), .dout_vld(dout_vld), .dout_rdy(dout_rdy), .size(size),
        .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .max_level(max_level)
    );

    fifo_wm #(.WIDTH(8), .DEPTH(32), .OREG(0)) u_dut0 (
        .clk(clk), .rstz(rstz), .clear(u0_clear), .af_level(u0_af_level), .ae_level(u0_ae_level),
        .wm_clr(u0_wm_clr), .din(u0_din), .din_vld(u0_din_vld), .din_rdy(u0_din_rdy),
        .dout(u0_dout), .dout_vld(u0_dout_vld), .dout_rdy(u0_dout_rdy), .size(u0_size),
        .full(u0_full), .empty(u0_empty), .almost_full(u0_af),
        .almost_empty(u0_ae), .max_level(u0_max)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled at the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push1(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            din     = 8'(base + i);
            din_vld = 1'b1;
            tick();
        end
        din_vld = 1'b0;
    endtask

    task automatic drain1(input string tag, input int n, input int base);
        dout_rdy = 1'b1;
        for (int i = 0; i < n; i++) begin
            chk({tag, "_vld"}, 32'(dout_vld), 1);
            chk(tag, 32'(dout), 32'(8'(base + i)));
            tick();
        end
        dout_rdy = 1'b0;
    endtask

    initial begin
        int acc;
        int n;
        int sent;
        int got;
        checks = 0;
        errors = 0;
        rstz = 1'b0;
        clear = 1'b0; wm_clr = 1'b0; din_vld = 1'b0; dout_rdy = 1'b0; din = 8'h00;
        af_level = 6'd30; ae_level = 6'd2;
        u0_clear = 1'b0; u0_wm_clr = 1'b0; u0_din_vld = 1'b0; u0_dout_rdy = 1'b0; u0_din = 8'h00;
        u0_af_level = 6'd30; u0_ae_level = 6'd2;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_size", 32'(size), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_dout_vld", 32'(dout_vld), 0);
        chk("rst_dout", 32'(dout), 0);
        chk("rst_max", 32'(max_level), 0);
        chk("rst_u0_dout", 32'(u0_dout), 0);
        rstz = 1'b1;
        tick();
        chk("rst_din_rdy", 32'(din_rdy), 1);
        chk("rst_ae", 32'(almost_empty), 1);

        // OREG=1: 40 offered, 33 accepted
        acc = 0;
        for (int i = 0; i < 40; i++) begin
            din     = 8'(i);
            din_vld = 1'b1;
            if (din_rdy) acc++;
            tick();
        end
        din_vld = 1'b0;
        chk("fill_accepted", 32'(acc), 33);
        chk("fill_size", 32'(size), 33);
        chk("fill_full", 32'(full), 1);
        chk("fill_din_rdy", 32'(din_rdy), 0);
        chk("fill_max", 32'(max_level), 33);
        chk("fill_af", 32'(almost_full), 1);
        drain1("fill_data", 33, 0);
        chk("fill_empty", 32'(empty), 1);
        chk("fill_max_hold", 32'(max_level), 33);

        // Flush to zero the watermark, then step through the thresholds
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr0_max", 32'(max_level), 0);
        for (int k = 1; k <= 30; k++) begin
            din     = 8'(k);
            din_vld = 1'b1;
            tick();
            chk("thr_ae", 32'(almost_empty), 32'(k <= 2));
            chk("thr_af", 32'(almost_full), 32'(k >= 30));
        end
        din_vld = 1'b0;
        drain1("thr_data", 20, 1);
        chk("pre_clr_size", 32'(size), 10);

        // clear at size 10 with traffic offered on both sides
        clear = 1'b1; din_vld = 1'b1; din = 8'hEE; dout_rdy = 1'b1;
        tick();
        clear = 1'b0; din_vld = 1'b0; dout_rdy = 1'b0;
        chk("clr_size", 32'(size), 0);
        chk("clr_dout_vld", 32'(dout_vld), 0);
        chk("clr_max", 32'(max_level), 0);
        chk("clr_empty", 32'(empty), 1);
        tick();
        chk("clr_size_hold", 32'(size), 0);

        // Watermark clear then tracking
        push1(5, 8'h50);
        drain1("wm_data", 3, 8'h50);
        chk("wm_max5", 32'(max_level), 5);
        wm_clr = 1'b1;
        tick();
        wm_clr = 1'b0;
        chk("wm_cleared", 32'(max_level), 0);
        tick();
        chk("wm_track", 32'(max_level), 2);
        drain1("wm_tail", 2, 8'h53);

        // OREG=0: single push latency, then fill to 32
        u0_din = 8'hA5; u0_din_vld = 1'b1;
        tick();
        u0_din_vld = 1'b0;
        chk("u0_one_vld", 32'(u0_dout_vld), 1);
        chk("u0_one_dout", 32'(u0_dout), 32'h A5);
        chk("u0_one_size", 32'(u0_size), 1);
        u0_dout_rdy = 1'b1;
        tick();
        u0_dout_rdy = 1'b0;
        chk("u0_one_empty", 32'(u0_empty), 1);
        for (int i = 0; i < 32; i++) begin
            u0_din = 8'(8'h10 + i); u0_din_vld = 1'b1;
            tick();
        end
        u0_din_vld = 1'b0;
        chk("u0_full", 32'(u0_full), 1);
        chk("u0_size", 32'(u0_size), 32);
        chk("u0_din_rdy", 32'(u0_din_rdy), 0);
        u0_dout_rdy = 1'b1;
        for (int i = 0; i < 32; i++) begin
            chk("u0_data", 32'(u0_dout), 32'(8'(8'h10 + i)));
            tick();
        end
        u0_dout_rdy = 1'b0;
        chk("u0_end_empty", 32'(u0_empty), 1);

        // Random length, random throttle on both sides, OREG=1
        n = int'($urandom_range(2, 512));
        sent = 0;
        got = 0;
        q.delete();
        for (int cyc = 0; cyc < 20000 && got < n; cyc++) begin
            din_vld  = (sent < n) && ($urandom_range(0, 3) != 0);
            din      = 8'($urandom);
            dout_rdy = ($urandom_range(0, 2) != 0);
            #1;
            if (dout_vld && dout_rdy) begin
                if (q.size() == 0) chk("rnd_underflow", 1, 0);
                else chk("rnd_data", 32'(dout), 32'(q.pop_front()));
                got++;
            end
            if (din_vld && din_rdy) begin
                q.push_back(din);
                sent++;
            end
            tick();
        end
        din_vld = 1'b0;
        dout_rdy = 1'b0;
        chk("rnd_count", 32'(got), 32'(n));
        chk("rnd_size", 32'(size), 0);
        chk("rnd_empty", 32'(empty), 1);

        // Asynchronous reset at size 17 mid-traffic
        push1(17, 8'h20);
        chk("arst_pre_size", 32'(size), 17);
        din_vld = 1'b1; din = 8'h77; dout_rdy = 1'b1;
        #2;
        rstz = 1'b0;
        #1;
        chk("arst_size", 32'(size), 0);
        chk("arst_dout_vld", 32'(dout_vld), 0);
        din_vld = 1'b0; dout_rdy = 1'b0;
        @(negedge clk);
        rstz = 1'b1;
        tick();
        chk("arst_din_rdy", 32'(din_rdy), 1);
        chk("arst_size_post", 32'(size), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
